// File: rtl/jk_counter_ctrl.sv
// ---------------------------------------------------------------------------
// jk_counter_ctrl
//
// Modulo-MODULUS up/down counter whose state is held in a bank of JK
// flip-flops, one per bit. The block computes the J/K excitation for that
// bank every cycle. It also keeps the bank state itself (r_q), so it can run
// standalone or sit upstream of an external JK register.
//
// Parameters
//   WIDTH    bit width of count, din, J and K
//   MODULUS  count range 0..MODULUS-1; legal range is 2..2**WIDTH
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   asynchronous, active-high; clears the count
//   en     in   count enable
//   up     in   direction: 1 = increment, 0 = decrement
//   load   in   synchronous parallel load; wins over en
//   din    in   load value; saturates to MODULUS-1 when out of range
//   Q      out  present count (JK bank state)
//   Qnot   out  bitwise complement of Q
//   J      out  J excitation for the next clock edge (combinational)
//   K      out  K excitation for the next clock edge (combinational)
//   tc     out  terminal count; a wrap happens on the next edge (combinational)
//   wrap   out  registered one-cycle pulse in the cycle after a wrap
// ---------------------------------------------------------------------------
module jk_counter_ctrl #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qnot,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             tc,
  output logic             wrap
);

  // MODULUS may equal 2**WIDTH, so the range check needs one extra bit.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_Q  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(32'd1);

  // Selects which excitation form drives the JK bank this cycle.
  typedef enum logic [1:0] {
    EXC_IDLE  = 2'd0,
    EXC_LOAD  = 2'd1,
    EXC_COUNT = 2'd2
  } exc_mode_t;

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic [WIDTH-1:0] w_target;
  exc_mode_t        w_mode;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic [WIDTH-1:0] w_q_next;
  logic             w_q_legal;
  logic             w_din_legal;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_tc;

  // Single JK flip-flop: 00 hold, 01 clear, 10 set, 11 toggle.
  function automatic logic jk_bit(input logic q, input logic j, input logic k);
    logic nxt;
    case ({j, k})
      2'b00:   nxt = q;
      2'b01:   nxt = 1'b0;
      2'b10:   nxt = 1'b1;
      2'b11:   nxt = ~q;
      default: nxt = q;
    endcase
    return nxt;
  endfunction

  assign w_q_legal   = ({1'b0, r_q} < MOD_EXT);
  assign w_din_legal = ({1'b0, din} < MOD_EXT);
  assign w_at_max    = (r_q == MAX_Q);
  assign w_at_zero   = (r_q == ZERO_Q);

  // Next-state target and excitation mode: load, then count, then idle.
  // An out-of-range state recovers on the next count edge. Counting up
  // goes to 0. Counting down goes to MODULUS-1.
  always_comb begin
    w_target = r_q;
    w_mode   = EXC_IDLE;
    if (load) begin
      w_mode = EXC_LOAD;
      if (w_din_legal) begin
        w_target = din;
      end else begin
        w_target = MAX_Q;
      end
    end else if (en) begin
      w_mode = EXC_COUNT;
      if (up) begin
        if (w_at_max || !w_q_legal) begin
          w_target = ZERO_Q;
        end else begin
          w_target = r_q + ONE_Q;
        end
      end else begin
        if (w_at_zero || !w_q_legal) begin
          w_target = MAX_Q;
        end else begin
          w_target = r_q - ONE_Q;
        end
      end
    end else begin
      w_mode   = EXC_IDLE;
      w_target = r_q;
    end
  end

  // Excitation encoding.
  // A load uses set/reset form, so the result does not depend on the old state.
  // A count uses toggle form, so only the bits that change are excited.
  always_comb begin
    w_j = {WIDTH{1'b0}};
    w_k = {WIDTH{1'b0}};
    case (w_mode)
      EXC_LOAD: begin
        w_j = w_target;
        w_k = ~w_target;
      end
      EXC_COUNT: begin
        w_j = r_q ^ w_target;
        w_k = r_q ^ w_target;
      end
      EXC_IDLE: begin
        w_j = {WIDTH{1'b0}};
        w_k = {WIDTH{1'b0}};
      end
      default: begin
        w_j = {WIDTH{1'b0}};
        w_k = {WIDTH{1'b0}};
      end
    endcase
  end

  // Terminal count means the next edge wraps. A load suppresses it.
  assign w_tc = en & ~load & ((up & w_at_max) | (~up & w_at_zero));

  // Next value of each bank bit, taken only from its own J/K pair.
  always_comb begin
    w_q_next = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      w_q_next[i] = jk_bit(r_q[i], w_j[i], w_k[i]);
    end
  end

  // JK bank state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= {WIDTH{1'b0}};
    end else begin
      r_q <= w_q_next;
    end
  end

  // Wrap pulse: registered terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_tc;
    end
  end

  assign Q    = r_q;
  assign Qnot = ~r_q;
  assign J    = w_j;
  assign K    = w_k;
  assign tc   = w_tc;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_jk_counter_ctrl
//
// Scoreboard bench for jk_counter_ctrl (WIDTH=4, MODULUS=10).
// The stimulus process drives inputs shortly after each rising edge and
// pushes the hand-computed expected outputs for that cycle. The monitor
// process pops one entry at each falling edge and compares it against the
// DUT outputs.
// ---------------------------------------------------------------------------
module tb_jk_counter_ctrl;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk;
  logic         reset;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] din;
  logic [W-1:0] Q;
  logic [W-1:0] Qnot;
  logic [W-1:0] J;
  logic [W-1:0] K;
  logic         tc;
  logic         wrap;

  typedef struct {
    string      name;
    logic [3:0] q;
    logic [3:0] j;
    logic [3:0] k;
    logic       tc;
    logic       wr;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // J = K excitation for each up-count step from Q = 0..9.
  logic [3:0] upjk [10];

  jk_counter_ctrl #(.WIDTH(W), .MODULUS(M)) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .up    (up),
    .load  (load),
    .din   (din),
    .Q     (Q),
    .Qnot  (Qnot),
    .J     (J),
    .K     (K),
    .tc    (tc),
    .wrap  (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld,
                     input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s got=%b want=%b", nm, fld, act, exp);
    end
  endtask

  task automatic step(input string nm, input logic rs, input logic e_,
                      input logic u_, input logic l_, input logic [3:0] d_,
                      input logic [3:0] eq, input logic [3:0] ej,
                      input logic [3:0] ek, input logic etc,
                      input logic ewr, input logic frc);
    exp_t x;
    @(posedge clk);
    #1;
    if (frc) begin
      force dut.r_q = 4'd12;
      #1;
      release dut.r_q;
    end
    reset = rs;
    en    = e_;
    up    = u_;
    load  = l_;
    din   = d_;
    x.name = nm;
    x.q    = eq;
    x.j    = ej;
    x.k    = ek;
    x.tc   = etc;
    x.wr   = ewr;
    sb.push_back(x);
  endtask

  // Monitor: compares one expected entry per falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp(e.name, "Q",    Q,    e.q);
        cmp(e.name, "Qnot", Qnot, ~e.q);
        cmp(e.name, "J",    J,    e.j);
        cmp(e.name, "K",    K,    e.k);
        cmp(e.name, "tc",   {3'b000, tc},   {3'b000, e.tc});
        cmp(e.name, "wrap", {3'b000, wrap}, {3'b000, e.wr});
      end
    end
  end

  // Watchdog.
  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    upjk = '{4'b0001, 4'b0011, 4'b0001, 4'b0111, 4'b0001,
             4'b0011, 4'b0001, 4'b1111, 4'b0001, 4'b1001};
    reset = 1'b1;
    en    = 1'b0;
    up    = 1'b0;
    load  = 1'b0;
    din   = 4'd0;
    repeat (2) @(posedge clk);

    // Reset state.
    step("rst_hold", 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Count up to 7, then assert reset mid-count.
    for (int i = 0; i < 7; i++) begin
      step("pre_up", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'(i), upjk[i], upjk[i], 1'b0, 1'b0, 1'b0);
    end
    step("at7", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step("rst_async", 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("rst_idle", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    end

    // Up count over the wrap: 0..9, 0, 1, then settle at 2.
    for (int i = 0; i < 12; i++) begin
      step("up", 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'(i % 10), upjk[i % 10], upjk[i % 10],
           (i == 9), (i == 10), 1'b0);
    end
    step("up_end", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Load 0, then count down over the wrap: 0 -> 9 -> 8 -> 7.
    step("ld0",    1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd2, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0);
    step("dn0",    1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'b1001, 4'b1001, 1'b1, 1'b0, 1'b0);
    step("dn9",    1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0);
    step("dn8",    1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd8, 4'b1111, 4'b1111, 1'b0, 1'b0, 1'b0);
    step("dn_end", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd7, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Load priority and saturation.
    step("ld5",    1'b0, 1'b1, 1'b1, 1'b1, 4'b0101, 4'd7, 4'b0101, 4'b1010, 1'b0, 1'b0, 1'b0);
    step("ld_sat", 1'b0, 1'b1, 1'b1, 1'b1, 4'b1110, 4'd5, 4'b1001, 4'b0110, 1'b0, 1'b0, 1'b0);
    step("ld_tc",  1'b0, 1'b1, 1'b1, 1'b1, 4'b0011, 4'd9, 4'b0011, 4'b1100, 1'b0, 1'b0, 1'b0);

    // Direction flip at Q = 3: 4, 3, 4, 3.
    step("flip0",    1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 4'b0111, 4'b0111, 1'b0, 1'b0, 1'b0);
    step("flip1",    1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 4'b0111, 4'b0111, 1'b0, 1'b0, 1'b0);
    step("flip2",    1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 4'b0111, 4'b0111, 1'b0, 1'b0, 1'b0);
    step("flip3",    1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd4, 4'b0111, 4'b0111, 1'b0, 1'b0, 1'b0);
    step("flip_end", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd3, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // Illegal-state recovery from a forced Q = 12.
    step("ill_up",     1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd12, 4'b1100, 4'b1100, 1'b0, 1'b0, 1'b1);
    step("ill_up_res", 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0,  4'd0,    4'd0,    1'b0, 1'b0, 1'b0);
    step("ill_dn",     1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd12, 4'b0101, 4'b0101, 1'b0, 1'b0, 1'b1);
    step("ill_dn_res", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd9,  4'd0,    4'd0,    1'b0, 1'b0, 1'b0);

    // First out-of-range load value (din = MODULUS) saturates to 9.
    step("ld10",   1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 4'd9, 4'b1001, 4'b0110, 1'b0, 1'b0, 1'b0);
    step("ld_end", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0,    4'd9, 4'd0,    4'd0,    1'b0, 1'b0, 1'b0);

    // Drain the scoreboard within a bounded number of cycles.
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jk_counter_ctrl.md
Name: jk_counter_ctrl

Overview:
- Synchronous modulo-N up/down counter whose state register is a bank of JK flip-flops (one per bit).
- Sits directly upstream of the JK flip-flop bank. It computes the per-bit J/K excitation that drives that bank, and also holds the bank state internally so it can run standalone.
- Outputs the present count, its complement, the J/K excitation vectors and terminal-count/wrap flags for cascading (e.g. BCD digit chains).

Parameters:
WIDTH, 4, bit width of count, J, K, din
MODULUS, 10, count range 0..MODULUS-1; legal range 2..2**WIDTH

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears counter
en  input  1  count enable
up  input  1  direction: 1 = increment, 0 = decrement
load  input  1  synchronous parallel load; priority over en
din  input  WIDTH  load value
Q  output  WIDTH  present count (JK bank state)
Qnot  output  WIDTH  bitwise complement of Q
J  output  WIDTH  J excitation for next clock edge
K  output  WIDTH  K excitation for next clock edge
tc  output  1  terminal count (combinational)
wrap  output  1  registered one-cycle pulse after a wrap transition

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values, applied immediately on reset assertion regardless of clk:
  - Q = 0, Qnot = all 1s, wrap = 0.
  - J, K and tc follow the combinational rules below from Q = 0.
- State update: every bit of Q updates on the rising clk edge by JK semantics from its own J[i]/K[i]:
  - 00 = hold, 01 = clear, 10 = set, 11 = toggle.
  - The RTL must realise Q through this JK rule, not by a direct next = f(Q) assignment.
- Next-state target N, priority order:
  - load=1: N = din if din < MODULUS, else N = MODULUS-1 (saturate).
  - else en=1, up=1: N = Q+1, or 0 when Q == MODULUS-1.
  - else en=1, up=0: N = Q-1, or MODULUS-1 when Q == 0.
  - else: N = Q.
- Excitation encoding:
  - Load cycle: set/reset form for all bits, J[i] = N[i], K[i] = ~N[i].
  - Count cycle: toggle form, J[i] = K[i] = Q[i] ^ N[i].
  - Idle: J = K = 0.
- tc = en & ~load & ((up & Q == MODULUS-1) | (~up & Q == 0)).
- wrap: registered copy of tc. It is high exactly in the cycle after Q wrapped, and is cleared when reset is asserted.
- Illegal state: if Q is ever >= MODULUS (possible only when MODULUS < 2**WIDTH):
  - Count up forces N = 0.
  - Count down forces N = MODULUS-1.
  - The design must never lock up.
- Simultaneous events:
  - load and en together: load wins; tc = 0; wrap is 0 on the next cycle.
  - Direction change mid-count: takes effect on the same edge, with no extra latency.
- Reset mid-operation: Q clears within the same cycle; pending load/count is discarded; the counter resumes from 0 on the first edge after reset deasserts.
- Latency: one clock from en/load to updated Q.
- Combinational paths: J, K and tc are combinational from Q/en/up/load/din, with no combinational path from the clock.

Test Plan:
1. Reset and hold:
   - Stimulus: assert reset mid-count at Q = 7.
   - Required: Q = 0, Qnot = 1111 without waiting for an edge.
   - Then reset = 0, en = 0 for 3 cycles: Q stays 0, J = K = 0000.
2. Up count and wrap (MODULUS = 10, en = 1, up = 1, 12 cycles from 0):
   - Q sequence 1..9, 0, 1, 2.
   - tc = 1 only while Q = 9; wrap = 1 only in the cycle Q = 0 after the wrap.
   - J = K = 1001 at Q = 9.
3. Down count and wrap (en = 1, up = 0, from 0):
   - Q sequence 9, 8, 7.
   - tc = 1 while Q = 0, with J = K = 1001.
4. Load priority and saturation:
   - load = 1, en = 1, din = 0101: Q = 5 next edge; J = 0101, K = 1010; tc = 0.
   - din = 1110: Q = 9 (saturated).
5. Direction flip:
   - At Q = 3, toggle up between 1 and 0 each cycle.
   - Q sequence 4, 3, 4, 3; J = K = 0111 on the 3 -> 4 steps.
6. Illegal-state recovery (WIDTH = 4, MODULUS = 10, Q forced to 12 via bench force/release):
   - up = 1 gives Q = 0 next edge.
   - Re-force Q = 12, up = 0 gives Q = 9 next edge.
